vp_validation_unit: RTL and testbench

Feedback-side companion of the last-value predictor. Captures each prediction the predictor emits, holds it in an in-order in-flight buffer until the execution result for that instruction arrives, and compares predicted against actual. It then drives the predictor's feedback interface (pc, actual value, mispredict flag, confidence echo, valid). It sits between the predictor's prediction outputs and the core's execute/commit result stream.

---
 rtl/vp_pkg.sv | 14 +
 rtl/vp_inflight_fifo.sv | 108 ++++++++++
 rtl/vp_validation_unit.sv | 143 ++++++++++++++
 tb/tb_vp_validation_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared types and default sizing for the value-prediction validation unit.
package vp_pkg;

    localparam int unsigned VP_NUM_PRED   = 2;
    localparam int unsigned VP_CONF_WIDTH = 8;
    localparam int unsigned VP_DEPTH      = 16;

    typedef struct packed {
        logic [31:1]            pc;
        logic [31:0]            result;
        logic [VP_CONF_WIDTH:0] conf;
    } vp_entry_t;

endpackage

// File: rtl/vp_inflight_fifo.sv
// In-order multi-lane in-flight buffer: compacted enqueue with drop on lack of
// space, compacted dequeue matched against head, head+1 using pre-cycle count.
module vp_inflight_fifo
    import vp_pkg::*;
#(
    parameter int unsigned P_NUM_PRED = VP_NUM_PRED,
    parameter int unsigned P_DEPTH    = VP_DEPTH
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       flush_i,
    input  logic      [P_NUM_PRED-1:0]                 enq_valid_i,
    input  vp_entry_t [P_NUM_PRED-1:0]                 enq_data_i,
    input  logic      [P_NUM_PRED-1:0]                 deq_valid_i,
    output logic      [P_NUM_PRED-1:0]                 deq_match_o,
    output logic      [P_NUM_PRED-1:0][$clog2(P_DEPTH):0] deq_pos_o,
    output vp_entry_t [P_NUM_PRED-1:0]                 deq_entry_o,
    output logic      [$clog2(P_DEPTH):0]              drop_cnt_o,
    output logic      [$clog2(P_DEPTH):0]              count_o
);

    localparam int unsigned PTR_W = $clog2(P_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    vp_entry_t        r_mem [P_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_run_e;
    logic [CNT_W-1:0] w_run_d;
    logic [CNT_W-1:0] w_n_acc;
    logic [CNT_W-1:0] w_n_drop;
    logic [CNT_W-1:0] w_n_pop;
    logic [P_NUM_PRED-1:0] w_enq_acc;
    logic [P_NUM_PRED-1:0][CNT_W-1:0] w_enq_pos;
    logic [P_NUM_PRED-1:0][CNT_W-1:0] w_deq_pos;
    logic [P_NUM_PRED-1:0] w_deq_match;

    // Lane compaction: each valid lane takes the next slot after the valid lanes before it.
    always_comb begin
        w_free      = CNT_W'(P_DEPTH) - r_count;
        w_run_e     = '0;
        w_run_d     = '0;
        w_n_acc     = '0;
        w_n_drop    = '0;
        w_n_pop     = '0;
        w_enq_acc   = '0;
        w_enq_pos   = '0;
        w_deq_pos   = '0;
        w_deq_match = '0;
        for (int i = 0; i < int'(P_NUM_PRED); i++) begin
            w_enq_pos[i] = w_run_e;
            if (enq_valid_i[i]) begin
                w_run_e = w_run_e + CNT_W'(1);
                if (w_enq_pos[i] < w_free) begin
                    w_enq_acc[i] = 1'b1;
                    w_n_acc      = w_n_acc + CNT_W'(1);
                end else begin
                    w_n_drop = w_n_drop + CNT_W'(1);
                end
            end
            w_deq_pos[i] = w_run_d;
            if (deq_valid_i[i]) begin
                w_run_d = w_run_d + CNT_W'(1);
                if (w_deq_pos[i] < r_count) begin
                    w_deq_match[i] = 1'b1;
                    w_n_pop        = w_n_pop + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(P_NUM_PRED); i++) begin
            deq_entry_o[i] = r_mem[r_head + PTR_W'(w_deq_pos[i])];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            for (int i = 0; i < int'(P_NUM_PRED); i++) begin
                if (w_enq_acc[i]) begin
                    r_mem[r_tail + PTR_W'(w_enq_pos[i])] <= enq_data_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PTR_W'(w_n_acc);
            r_head  <= r_head + PTR_W'(w_n_pop);
            r_count <= r_count + w_n_acc - w_n_pop;
        end
    end

    assign deq_match_o = w_deq_match;
    assign deq_pos_o   = w_deq_pos;
    assign drop_cnt_o  = w_n_drop;
    assign count_o     = r_count;

endmodule

// File: rtl/vp_validation_unit.sv
// Holds in-flight predictions, compares them with execution results and drives
// registered predictor feedback plus overflow/order-error statistics.
module vp_validation_unit
    import vp_pkg::*;
#(
    parameter int unsigned P_NUM_PRED   = VP_NUM_PRED,
    parameter int unsigned P_CONF_WIDTH = VP_CONF_WIDTH,
    parameter int unsigned P_DEPTH      = VP_DEPTH
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [P_NUM_PRED-1:0][31:1]             pred_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]             pred_result_i,
    input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]   pred_conf_i,
    input  logic [P_NUM_PRED-1:0]                   pred_valid_i,
    input  logic [P_NUM_PRED-1:0][31:1]             exe_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]             exe_result_i,
    input  logic [P_NUM_PRED-1:0]                   exe_valid_i,
    input  logic                                    flush_i,
    output logic [P_NUM_PRED-1:0][31:1]             fb_pc_o,
    output logic [P_NUM_PRED-1:0][31:0]             fb_actual_o,
    output logic [P_NUM_PRED-1:0]                   fb_mispredict_o,
    output logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]   fb_conf_o,
    output logic [P_NUM_PRED-1:0]                   fb_valid_o,
    output logic [$clog2(P_DEPTH):0]                occupancy_o,
    output logic [15:0]                             overflow_cnt_o,
    output logic                                    order_err_o
);

    localparam int unsigned CNT_W = $clog2(P_DEPTH) + 1;
    localparam int unsigned SC_W  = VP_CONF_WIDTH + 1;
    localparam int unsigned FC_W  = P_CONF_WIDTH + 1;

    vp_entry_t [P_NUM_PRED-1:0]            w_enq_data;
    vp_entry_t [P_NUM_PRED-1:0]            w_deq_entry;
    logic      [P_NUM_PRED-1:0]            w_deq_match;
    logic      [P_NUM_PRED-1:0][CNT_W-1:0] w_deq_pos;
    logic      [CNT_W-1:0]                 w_drop;
    logic      [CNT_W-1:0]                 w_count;

    logic [P_NUM_PRED-1:0][31:1]       w_fb_pc,     r_fb_pc;
    logic [P_NUM_PRED-1:0][31:0]       w_fb_actual, r_fb_actual;
    logic [P_NUM_PRED-1:0]             w_fb_mis,    r_fb_mis;
    logic [P_NUM_PRED-1:0][FC_W-1:0]   w_fb_conf,   r_fb_conf;
    logic [P_NUM_PRED-1:0]             w_fb_valid,  r_fb_valid;
    logic                              w_err;
    logic [16:0]                       w_ovf_sum;
    logic [15:0]                       r_ovf;
    logic                              r_err;

    always_comb begin
        for (int i = 0; i < int'(P_NUM_PRED); i++) begin
            w_enq_data[i].pc     = pred_pc_i[i];
            w_enq_data[i].result = pred_result_i[i];
            w_enq_data[i].conf   = SC_W'(pred_conf_i[i]);
        end
    end

    vp_inflight_fifo #(
        .P_NUM_PRED (P_NUM_PRED),
        .P_DEPTH    (P_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .enq_valid_i (pred_valid_i),
        .enq_data_i  (w_enq_data),
        .deq_valid_i (exe_valid_i),
        .deq_match_o (w_deq_match),
        .deq_pos_o   (w_deq_pos),
        .deq_entry_o (w_deq_entry),
        .drop_cnt_o  (w_drop),
        .count_o     (w_count)
    );

    // Matched exe lane i lands on feedback lane deq_pos[i]; a pc mismatch echoes exe pc.
    always_comb begin
        w_fb_pc     = '0;
        w_fb_actual = '0;
        w_fb_mis    = '0;
        w_fb_conf   = '0;
        w_fb_valid  = '0;
        w_err       = 1'b0;
        for (int k = 0; k < int'(P_NUM_PRED); k++) begin
            for (int i = 0; i < int'(P_NUM_PRED); i++) begin
                if (w_deq_match[i] && (w_deq_pos[i] == CNT_W'(k))) begin
                    w_fb_valid[k]  = 1'b1;
                    w_fb_actual[k] = exe_result_i[i];
                    if (exe_pc_i[i] != w_deq_entry[i].pc) begin
                        w_fb_pc[k]  = exe_pc_i[i];
                        w_fb_mis[k] = 1'b1;
                    end else begin
                        w_fb_pc[k]   = w_deq_entry[i].pc;
                        w_fb_mis[k]  = (w_deq_entry[i].result != exe_result_i[i]);
                        w_fb_conf[k] = FC_W'(w_deq_entry[i].conf);
                    end
                end
            end
        end
        for (int i = 0; i < int'(P_NUM_PRED); i++) begin
            if (exe_valid_i[i] && (!w_deq_match[i] || (exe_pc_i[i] != w_deq_entry[i].pc))) begin
                w_err = 1'b1;
            end
        end
        w_ovf_sum = 17'(r_ovf) + 17'(w_drop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fb_pc     <= '0;
            r_fb_actual <= '0;
            r_fb_mis    <= '0;
            r_fb_conf   <= '0;
            r_fb_valid  <= '0;
            r_ovf       <= '0;
            r_err       <= 1'b0;
        end else if (flush_i) begin
            r_fb_pc     <= '0;
            r_fb_actual <= '0;
            r_fb_mis    <= '0;
            r_fb_conf   <= '0;
            r_fb_valid  <= '0;
        end else begin
            r_fb_pc     <= w_fb_pc;
            r_fb_actual <= w_fb_actual;
            r_fb_mis    <= w_fb_mis;
            r_fb_conf   <= w_fb_conf;
            r_fb_valid  <= w_fb_valid;
            r_ovf       <= (w_ovf_sum > 17'h0FFFF) ? 16'hFFFF : w_ovf_sum[15:0];
            r_err       <= r_err | w_err;
        end
    end

    assign fb_pc_o         = r_fb_pc;
    assign fb_actual_o     = r_fb_actual;
    assign fb_mispredict_o = r_fb_mis;
    assign fb_conf_o       = r_fb_conf;
    assign fb_valid_o      = r_fb_valid;
    assign occupancy_o     = w_count;
    assign overflow_cnt_o  = r_ovf;
    assign order_err_o     = r_err;

endmodule

// File: tb/tb_vp_validation_unit.sv
// Directed scoreboard bench for vp_validation_unit: stimulus pushes expected
// feedback, a negedge monitor pops and compares every fb lane it sees.
module tb_vp_validation_unit;

    logic              clk;
    logic              rst_i;
    logic [1:0][31:1]  pred_pc_i;
    logic [1:0][31:0]  pred_result_i;
    logic [1:0][8:0]   pred_conf_i;
    logic [1:0]        pred_valid_i;
    logic [1:0][31:1]  exe_pc_i;
    logic [1:0][31:0]  exe_result_i;
    logic [1:0]        exe_valid_i;
    logic              flush_i;
    logic [1:0][31:1]  fb_pc_o;
    logic [1:0][31:0]  fb_actual_o;
    logic [1:0]        fb_mispredict_o;
    logic [1:0][8:0]   fb_conf_o;
    logic [1:0]        fb_valid_o;
    logic [4:0]        occupancy_o;
    logic [15:0]       overflow_cnt_o;
    logic              order_err_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] act;
        logic        mis;
        logic [8:0]  conf;
        int          lane;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    vp_validation_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pred_pc_i       (pred_pc_i),
        .pred_result_i   (pred_result_i),
        .pred_conf_i     (pred_conf_i),
        .pred_valid_i    (pred_valid_i),
        .exe_pc_i        (exe_pc_i),
        .exe_result_i    (exe_result_i),
        .exe_valid_i     (exe_valid_i),
        .flush_i         (flush_i),
        .fb_pc_o         (fb_pc_o),
        .fb_actual_o     (fb_actual_o),
        .fb_mispredict_o (fb_mispredict_o),
        .fb_conf_o       (fb_conf_o),
        .fb_valid_o      (fb_valid_o),
        .occupancy_o     (occupancy_o),
        .overflow_cnt_o  (overflow_cnt_o),
        .order_err_o     (order_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pred(input int lane, input logic [31:0] addr, input logic [31:0] res,
                        input logic [8:0] conf);
        pred_valid_i[lane]  = 1'b1;
        pred_pc_i[lane]     = addr[31:1];
        pred_result_i[lane] = res;
        pred_conf_i[lane]   = conf;
    endtask

    task automatic exe(input int lane, input logic [31:0] addr, input logic [31:0] res);
        exe_valid_i[lane]  = 1'b1;
        exe_pc_i[lane]     = addr[31:1];
        exe_result_i[lane] = res;
    endtask

    task automatic expect_fb(input int lane, input logic [31:0] addr, input logic [31:0] act,
                             input logic mis, input logic [8:0] conf);
        exp_t e;
        e.addr = addr; e.act = act; e.mis = mis; e.conf = conf; e.lane = lane;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        pred_valid_i = '0;
        exe_valid_i  = '0;
        flush_i      = 1'b0;
    endtask

    task automatic drain_one(input int lane, input int j);
        logic [31:0] addr;
        logic [31:0] act;
        addr = 32'h400 + 32'(4 * j);
        act  = (j == 7) ? 32'hDEAD : 32'h1000 + 32'(j);
        exe(lane, addr, act);
        expect_fb(lane, addr, act, (j == 7), 9'(j));
    endtask

    // Feedback monitor: every valid fb lane must match the oldest expected entry.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (fb_valid_o[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fb_unexpected: lane %0d got pc 0x%0h, expected no feedback",
                             k, {fb_pc_o[k], 1'b0});
                end else begin
                    mon_e = sb.pop_front();
                    chk("fb_lane", 32'(k), 32'(mon_e.lane));
                    chk("fb_pc", {fb_pc_o[k], 1'b0}, mon_e.addr);
                    chk("fb_actual", fb_actual_o[k], mon_e.act);
                    chk("fb_mispredict", 32'(fb_mispredict_o[k]), 32'(mon_e.mis));
                    chk("fb_conf", 32'(fb_conf_o[k]), 32'(mon_e.conf));
                end
            end
        end
    end

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        pred_pc_i     = '0;
        pred_result_i = '0;
        pred_conf_i   = '0;
        pred_valid_i  = '0;
        exe_pc_i      = '0;
        exe_result_i  = '0;
        exe_valid_i   = '0;
        cyc();
        cyc();
        rst_i = 1'b0;
        chk("rst_occupancy", 32'(occupancy_o), 32'd0);
        chk("rst_overflow", 32'(overflow_cnt_o), 32'd0);
        chk("rst_order_err", 32'(order_err_o), 32'd0);
        chk("rst_fb_valid", 32'(fb_valid_o), 32'd0);

        // Two-wide prediction, one correct and one wrong.
        pred(0, 32'h100, 32'd5, 9'h080);
        pred(1, 32'h104, 32'd7, 9'h100);
        cyc();
        chk("t1_occ_after_enq", 32'(occupancy_o), 32'd2);
        exe(0, 32'h100, 32'd5);
        exe(1, 32'h104, 32'd9);
        expect_fb(0, 32'h100, 32'd5, 1'b0, 9'h080);
        expect_fb(1, 32'h104, 32'd9, 1'b1, 9'h100);
        cyc();
        chk("t1_occ_after_deq", 32'(occupancy_o), 32'd0);
        cyc();

        // Lone lane-1 prediction, then lone lane-1 exe compacting onto fb lane 0.
        pred(1, 32'h200, 32'h11, 9'h1FF);
        cyc();
        chk("t2_occ", 32'(occupancy_o), 32'd1);
        exe(0, 32'h200, 32'h11);
        expect_fb(0, 32'h200, 32'h11, 1'b0, 9'h1FF);
        cyc();
        chk("t2_order_err", 32'(order_err_o), 32'd0);
        pred(0, 32'h210, 32'h22, 9'h005);
        cyc();
        exe(1, 32'h210, 32'h23);
        expect_fb(0, 32'h210, 32'h23, 1'b1, 9'h005);
        cyc();
        chk("t2b_occ", 32'(occupancy_o), 32'd0);
        chk("t2b_order_err", 32'(order_err_o), 32'd0);

        // Pc mismatch against head.
        pred(0, 32'h304, 32'd3, 9'h055);
        cyc();
        exe(0, 32'h300, 32'd3);
        expect_fb(0, 32'h300, 32'd3, 1'b1, 9'h000);
        cyc();
        chk("t3_order_err", 32'(order_err_o), 32'd1);
        chk("t3_occ_popped", 32'(occupancy_o), 32'd0);

        // Fill to full starting at slot 5 so one pair straddles slots 15 and 0.
        for (int i = 0; i < 8; i++) begin
            pred(0, 32'h400 + 32'(8 * i), 32'h1000 + 32'(2 * i), 9'(2 * i));
            pred(1, 32'h404 + 32'(8 * i), 32'h1001 + 32'(2 * i), 9'(2 * i + 1));
            cyc();
        end
        chk("t4_occ_full", 32'(occupancy_o), 32'd16);
        chk("t4_ovf_zero", 32'(overflow_cnt_o), 32'd0);
        pred(0, 32'h900, 32'h1, 9'h1);
        pred(1, 32'h904, 32'h2, 9'h2);
        exe(0, 32'h400, 32'h1000);
        expect_fb(0, 32'h400, 32'h1000, 1'b0, 9'h000);
        cyc();
        chk("t4_ovf_two", 32'(overflow_cnt_o), 32'd2);
        chk("t4_occ_15", 32'(occupancy_o), 32'd15);
        for (int j = 1; j <= 15; j += 2) begin
            drain_one(0, j);
            if (j + 1 <= 15) drain_one(1, j + 1);
            cyc();
        end
        chk("t4_occ_drained", 32'(occupancy_o), 32'd0);
        chk("t4_order_err_sticky", 32'(order_err_o), 32'd1);
        cyc();

        // Flush with five entries plus a concurrent pred and exe.
        pred(0, 32'h700, 32'h70, 9'h7);
        pred(1, 32'h704, 32'h71, 9'h7);
        cyc();
        pred(0, 32'h708, 32'h72, 9'h7);
        pred(1, 32'h70C, 32'h73, 9'h7);
        cyc();
        pred(0, 32'h710, 32'h74, 9'h7);
        cyc();
        chk("t5_occ_5", 32'(occupancy_o), 32'd5);
        pred(0, 32'h714, 32'h75, 9'h7);
        exe(0, 32'h700, 32'h70);
        flush_i = 1'b1;
        cyc();
        chk("t5_occ_flushed", 32'(occupancy_o), 32'd0);
        chk("t5_ovf_kept", 32'(overflow_cnt_o), 32'd2);
        chk("t5_fb_valid", 32'(fb_valid_o), 32'd0);
        cyc();

        // Reset mid-stream with entries and concurrent traffic.
        pred(0, 32'h800, 32'h80, 9'h8);
        pred(1, 32'h804, 32'h81, 9'h8);
        cyc();
        chk("t6_occ_pre", 32'(occupancy_o), 32'd2);
        rst_i = 1'b1;
        pred(0, 32'h808, 32'h82, 9'h8);
        exe(0, 32'h800, 32'h80);
        cyc();
        rst_i = 1'b0;
        chk("t6_occ", 32'(occupancy_o), 32'd0);
        chk("t6_ovf", 32'(overflow_cnt_o), 32'd0);
        chk("t6_order_err", 32'(order_err_o), 32'd0);
        chk("t6_fb_valid", 32'(fb_valid_o), 32'd0);
        chk("t6_fb_pc", {fb_pc_o[0], 1'b0}, 32'd0);
        chk("t6_fb_actual", fb_actual_o[0], 32'd0);
        pred(0, 32'h500, 32'h77, 9'h012);
        cyc();
        chk("t6_occ_new", 32'(occupancy_o), 32'd1);
        exe(0, 32'h500, 32'h77);
        expect_fb(0, 32'h500, 32'h77, 1'b0, 9'h012);
        cyc();
        chk("t6_order_err_clean", 32'(order_err_o), 32'd0);
        chk("t6_occ_empty", 32'(occupancy_o), 32'd0);

        // Exe with nothing in flight.
        exe(0, 32'h600, 32'h1);
        cyc();
        chk("t7_order_err_empty", 32'(order_err_o), 32'd1);
        cyc();
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
